// File: rtl/sen_lut_arbiter_if.sv
// sen_lut_arbiter_if: requester/LUT/response bundle between the datapath and sen_lut_arbiter.
interface sen_lut_arbiter_if #(
    parameter int N = 4,
    parameter int W = 32
);
    logic [N-1:0]           req_valid;
    logic [N*W-1:0]         req_angle;
    logic [N-1:0]           req_ready;
    logic [W-1:0]           lut_angle;
    logic [W-1:0]           lut_value;
    logic                   resp_valid;
    logic [$clog2(N)-1:0]   resp_id;
    logic [W-1:0]           resp_value;
    logic                   busy;

    modport slave (
        input  req_valid, req_angle, lut_value,
        output req_ready, lut_angle, resp_valid, resp_id, resp_value, busy
    );
    modport master (
        output req_valid, req_angle, lut_value,
        input  req_ready, lut_angle, resp_valid, resp_id, resp_value, busy
    );
endinterface

// File: rtl/sen_lut_arbiter.sv
// sen_lut_arbiter: round-robin sharing of one SenLUT among N requesters with id-tagged responses.
module sen_lut_arbiter #(
    parameter int N       = 4,
    parameter int W       = 32,
    parameter int LUT_LAT = 1
) (
    input logic               clk,
    input logic               rst,
    sen_lut_arbiter_if.slave  bus
);
    localparam int IDW = $clog2(N);

    logic [IDW-1:0] r_ptr;
    logic [N-1:0]   r_pend;
    logic [W-1:0]   r_angle;
    logic [LUT_LAT:0] r_tag_v;
    logic [IDW-1:0] r_tag_id [LUT_LAT+1];

    logic [N-1:0]   w_elig;
    logic [N-1:0]   w_grant;
    logic [N-1:0]   w_clr;
    logic           w_hit;
    logic [IDW-1:0] w_gid;
    int             w_j;

    assign w_elig = bus.req_valid & ~r_pend;

    always_comb begin
        w_hit = 1'b0;
        w_gid = '0;
        w_j   = 0;
        for (int k = 0; k < N; k++) begin
            w_j = (int'(r_ptr) + k) % N;
            if (!w_hit && w_elig[w_j[IDW-1:0]]) begin
                w_hit = 1'b1;
                w_gid = w_j[IDW-1:0];
            end
        end
    end

    assign w_grant = w_hit ? (N'(1) << w_gid) : '0;
    // a response frees its requester at the same edge a new grant may claim another one
    assign w_clr   = r_tag_v[LUT_LAT] ? (N'(1) << r_tag_id[LUT_LAT]) : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr   <= '0;
            r_pend  <= '0;
            r_angle <= '0;
            r_tag_v <= '0;
            for (int k = 0; k <= LUT_LAT; k++) r_tag_id[k] <= '0;
        end else begin
            r_pend      <= (r_pend & ~w_clr) | w_grant;
            r_tag_v     <= {r_tag_v[LUT_LAT-1:0], w_hit};
            r_tag_id[0] <= w_gid;
            for (int k = 1; k <= LUT_LAT; k++) r_tag_id[k] <= r_tag_id[k-1];
            if (w_hit) begin
                r_angle <= bus.req_angle[w_gid*W +: W];
                r_ptr   <= (int'(w_gid) == N - 1) ? '0 : w_gid + 1'b1;
            end
        end
    end

    assign bus.req_ready  = rst ? '0 : w_grant;
    assign bus.lut_angle  = r_angle;
    assign bus.resp_valid = r_tag_v[LUT_LAT];
    assign bus.resp_id    = r_tag_id[LUT_LAT];
    assign bus.resp_value = bus.lut_value;
    assign bus.busy       = |r_pend;
endmodule
